// File: rtl/multb_seq.sv
// Sequential signed shift-add multiplier (sign-magnitude, one bit of |b| per clock).
// Optional macro MULTB_SEQ_EARLY_TERM_EN stops RUN once the remaining bits of |b| are zero.
module multb_seq #(
  parameter int DATAWIDTH = 12,
  parameter int COEFWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [COEFWIDTH-1:0]           a,
  input  logic [DATAWIDTH-1:0]           b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATAWIDTH+COEFWIDTH-1:0] r,
  output logic                           busy
);

  localparam int PW   = DATAWIDTH + COEFWIDTH;
  localparam int CNTW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [COEFWIDTH-1:0] mag_a;
  logic [DATAWIDTH-1:0] mag_b;
  logic                 sign;
  logic [PW-1:0]        acc;
  logic [CNTW-1:0]      count;

  logic [PW-1:0]        addend;
  logic [PW-1:0]        acc_next;
  logic                 last_bit;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Partial product for the current bit of |b| and the end-of-run decision.
  always_comb begin
    addend   = '0;
    if (mag_b[count])
      addend = {{(PW-COEFWIDTH){1'b0}}, mag_a} << count;
    acc_next = acc + addend;
`ifdef MULTB_SEQ_EARLY_TERM_EN
    last_bit = (count == CNTW'(DATAWIDTH-1)) || (((mag_b >> count) >> 1) == '0);
`else
    last_bit = (count == CNTW'(DATAWIDTH-1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      r         <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      sign      <= 1'b0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            // Two's-complement negate as unsigned keeps the most negative value exact.
            mag_a <= a[COEFWIDTH-1] ? (~a + 1'b1) : a;
            mag_b <= b[DATAWIDTH-1] ? (~b + 1'b1) : b;
            sign  <= a[COEFWIDTH-1] ^ b[DATAWIDTH-1];
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CNTW'(1);
          if (last_bit) begin
            r         <= sign ? (~acc_next + 1'b1) : acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
